muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the vc16 execute stage. It accepts a one-cycle start from the execute stage when the decoded instruction carries the mult or div flag. It runs a shift-add multiply or restoring unsigned divide over RV cycles while holding busy to stall the pipeline, then presents the result with a one-cycle done strobe. It also supports pipeline flush abort and divide-by-zero short-cut.

---
 rtl/muldiv_seq_if.sv | 25 ++
 rtl/muldiv_seq.sv | 134 +++++++++++++
 tb/tb_muldiv_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Handshake bundle between the vc16 execute stage (master) and the muldiv sequencer (slave).
interface muldiv_seq_if #(
  parameter int RV = 16
);
  logic          start_mult;
  logic          start_div;
  logic          flush;
  logic [RV-1:0] a;
  logic [RV-1:0] b;
  logic          busy;
  logic          done;
  logic [RV-1:0] result;
  logic [RV-1:0] remainder;
  logic          div_zero;

  modport master (
    output start_mult, start_div, flush, a, b,
    input  busy, done, result, remainder, div_zero
  );

  modport slave (
    input  start_mult, start_div, flush, a, b,
    output busy, done, result, remainder, div_zero
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative shift-add multiply / restoring unsigned divide for the vc16 execute stage.
// Define MULDIV_EARLY_EN to end a multiply as soon as the remaining multiplier bits are zero.
module muldiv_seq #(
  parameter int RV = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_seq_if.slave   bus
);
  localparam int CW = $clog2(RV);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t        state;
  logic [RV-1:0] acc;
  logic [RV-1:0] opa;
  logic [RV-1:0] opb;
  logic [CW-1:0] count;
  logic          busy_r;
  logic          done_r;
  logic [RV-1:0] result_r;
  logic [RV-1:0] remainder_r;
  logic          div_zero_r;

  logic [RV-1:0] mul_sum;
  logic [RV-1:0] opb_shr;
  logic          last_iter;
  logic          mul_last;
  logic [RV:0]   div_shift;
  logic          div_ge;
  logic [RV-1:0] div_rem;
  logic [RV-1:0] div_quot;

  assign mul_sum   = acc + (opb[0] ? opa : '0);
  assign opb_shr   = opb >> 1;
  assign last_iter = (count == CW'(RV - 1));

`ifdef MULDIV_EARLY_EN
  assign mul_last = last_iter || (opb_shr == '0);
`else
  assign mul_last = last_iter;
`endif

  // The shifted partial remainder keeps its carry-out bit so divisors above 2^(RV-1) compare correctly.
  assign div_shift = {acc, opa[RV-1]};
  assign div_ge    = (div_shift >= {1'b0, opb});
  assign div_rem   = div_ge ? (div_shift[RV-1:0] - opb) : div_shift[RV-1:0];
  assign div_quot  = {opa[RV-2:0], div_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      acc         <= '0;
      opa         <= '0;
      opb         <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= '0;
      remainder_r <= '0;
      div_zero_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.flush && (bus.start_mult || bus.start_div)) begin
            busy_r      <= 1'b1;
            acc         <= '0;
            opa         <= bus.a;
            opb         <= bus.b;
            count       <= '0;
            result_r    <= '0;
            remainder_r <= '0;
            div_zero_r  <= 1'b0;
            if (bus.start_mult) begin
              state <= MUL;
            end else if (bus.b == '0) begin
              state       <= DONE;
              done_r      <= 1'b1;
              result_r    <= '1;
              remainder_r <= bus.a;
              div_zero_r  <= 1'b1;
            end else begin
              state <= DIV;
            end
          end
        end
        MUL: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            acc   <= mul_sum;
            opa   <= opa << 1;
            opb   <= opb_shr;
            count <= count + 1'b1;
            if (mul_last) begin
              state       <= DONE;
              done_r      <= 1'b1;
              result_r    <= mul_sum;
              remainder_r <= '0;
            end
          end
        end
        DIV: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            acc   <= div_rem;
            opa   <= div_quot;
            count <= count + 1'b1;
            if (last_iter) begin
              state       <= DONE;
              done_r      <= 1'b1;
              result_r    <= div_quot;
              remainder_r <= div_rem;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.result    = result_r;
  assign bus.remainder = remainder_r;
  assign bus.div_zero  = div_zero_r;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed operations push expected results, a monitor checks each done.
module tb_muldiv_seq;
  localparam int RV = 16;

  typedef struct {
    logic [RV-1:0] res;
    logic [RV-1:0] rem;
    logic          dz;
    int            e0;
    int            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t sb[$];
  logic prev_done = 1'b0;

  muldiv_seq_if #(.RV(RV)) bus();
  muldiv_seq #(.RV(RV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int mul_lat(input logic [RV-1:0] bb);
    int n;
`ifdef MULDIV_EARLY_EN
    n = 1;
    for (int i = 0; i < RV; i++) if (bb[i]) n = i + 1;
`else
    n = RV;
`endif
    return n;
  endfunction

  // Monitor: every done strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (prev_done) chk("done_single_cycle", 32'd1, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'(bus.result), 32'(e.res));
        chk("remainder", 32'(bus.remainder), 32'(e.rem));
        chk("div_zero", 32'(bus.div_zero), 32'(e.dz));
        chk("latency", 32'(cyc - e.e0), 32'(e.lat));
      end
    end
    prev_done = rst_n && bus.done;
  end

  // Issue a start at the next edge; leaves the caller at the negedge following that edge.
  task automatic start_op(input logic m, input logic d, input logic [RV-1:0] aa,
                          input logic [RV-1:0] bb, input bit push,
                          input logic [RV-1:0] res, input logic [RV-1:0] rem,
                          input logic dz, input int lat);
    exp_t e;
    @(negedge clk);
    bus.start_mult = m;
    bus.start_div  = d;
    bus.a          = aa;
    bus.b          = bb;
    if (push) begin
      e.res = res; e.rem = rem; e.dz = dz; e.e0 = cyc + 1; e.lat = lat;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    chk("done_low_after", 32'(bus.done), 32'd0);
    chk("busy_low_after", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.flush      = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
    chk("rst_div_zero", 32'(bus.div_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    start_op(1'b1, 1'b0, 16'd3, 16'd5, 1, 16'd15, 16'd0, 1'b0, mul_lat(16'd5));
    wait_done();
    start_op(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1, 16'h0001, 16'd0, 1'b0, mul_lat(16'hFFFF));
    wait_done();
    start_op(1'b0, 1'b1, 16'd100, 16'd7, 1, 16'd14, 16'd2, 1'b0, RV);
    wait_done();
    start_op(1'b0, 1'b1, 16'h1234, 16'd0, 1, 16'hFFFF, 16'h1234, 1'b1, 0);
    wait_done();

    // Flush mid-divide, with a stray multiply start held while busy.
    start_op(1'b0, 1'b1, 16'd100, 16'd7, 0, '0, '0, 1'b0, 0);
    bus.start_mult = 1'b1;
    bus.a = 16'd9;
    bus.b = 16'd9;
    repeat (3) @(negedge clk);
    bus.start_mult = 1'b0;
    chk("busy_before_flush", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_result", 32'(bus.result), 32'd0);
    chk("flush_remainder", 32'(bus.remainder), 32'd0);
    chk("flush_div_zero", 32'(bus.div_zero), 32'd0);
    repeat (20) @(negedge clk);
    chk("flush_idle", 32'(bus.busy), 32'd0);

    start_op(1'b1, 1'b1, 16'd6, 16'd7, 1, 16'd42, 16'd0, 1'b0, mul_lat(16'd7));
    wait_done();
    chk("both_result_hold", 32'(bus.result), 32'd42);

    // Asynchronous reset in the middle of a multiply.
    start_op(1'b1, 1'b0, 16'd9, 16'd9, 0, '0, '0, 1'b0, 0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_result", 32'(bus.result), 32'd0);
    chk("arst_remainder", 32'(bus.remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(1'b1, 1'b0, 16'd9, 16'd9, 1, 16'd81, 16'd0, 1'b0, mul_lat(16'd9));
    wait_done();

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
